// File: rtl/servo_pkg.sv
// Shared constants and FSM state type for the servo sweep sequencer slice.
package servo_pkg;

  localparam int DUTY_W      = 8;
  localparam int PWM_TICK_HZ = 128000;
  localparam int FRAME_MS    = 20;
  localparam int DUTY_OFFSET = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } seq_state_e;

endpackage

// File: rtl/servo_sweep_sequencer_if.sv
// Target-position command channel: valid/ready handshake plus a bad-channel error pulse.
interface servo_sweep_sequencer_if;
  import servo_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_ch;
  logic [DUTY_W-1:0] cmd_target;
  logic              cmd_err;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_target,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_target,
    output cmd_ready,
    output cmd_err
  );

endinterface

// File: rtl/servo_frame_timer.sv
// PWM-tick prescaler and servo frame counter; frame_start marks the last tick of each frame.
module servo_frame_timer #(
  parameter int CLK_DIV     = 390,
  parameter int FRAME_TICKS = 2560
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [PW-1:0] presc_r;
  logic [FW-1:0] frame_r;

  assign tick        = (presc_r == PW'(CLK_DIV - 1));
  assign frame_start = tick && (frame_r == FW'(FRAME_TICKS - 1));

  // Prescaler and frame counter; the frame counter only moves on a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
      frame_r <= '0;
    end else begin
      if (tick) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      if (frame_start) begin
        frame_r <= '0;
      end else if (tick) begin
        frame_r <= frame_r + FW'(1);
      end else begin
        frame_r <= frame_r;
      end
    end
  end

endmodule

// File: rtl/servo_sweep_sequencer.sv
// Frame-aligned servo ramp sequencer: accepts targets while idle and, once per frame,
// steps every channel toward its target and strobes its latch.
module servo_sweep_sequencer
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_DIV     = 390,
  parameter int FRAME_TICKS = PWM_TICK_HZ * FRAME_MS / 1000,
  parameter int STEP        = 2,
  parameter int INIT_DUTY   = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  servo_sweep_sequencer_if.slave   cmd,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic [NUM_CH-1:0]        latch,
  output logic [NUM_CH-1:0]        at_target,
  output logic                     frame_start
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [8:0] STEP_S = 9'(STEP);

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [CW-1:0]     ch_idx_r;
  logic [CW-1:0]     ch_idx_nxt_s;
  logic [DUTY_W-1:0] cur_r [NUM_CH];
  logic [DUTY_W-1:0] tgt_r [NUM_CH];
  logic [NUM_CH-1:0] latch_r;
  logic              err_r;

  logic              tick_s;
  logic              timer_fs_s;
  logic              frame_start_s;
  logic              accept_s;
  logic              cmd_in_range_s;
  logic              proc_en_s;
  logic [DUTY_W-1:0] proc_cur_s;
  logic [DUTY_W-1:0] proc_tgt_s;
  logic [DUTY_W-1:0] proc_new_s;
  logic signed [8:0] diff_s;

  servo_frame_timer #(
    .CLK_DIV     (CLK_DIV),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick_s),
    .frame_start (timer_fs_s)
  );

  // Frame boundaries are only honoured on a prescaler tick.
  assign frame_start_s  = timer_fs_s & tick_s;
  assign frame_start    = frame_start_s;

  assign cmd.cmd_ready  = (state_r == IDLE);
  assign cmd.cmd_err    = err_r;
  assign accept_s       = cmd.cmd_valid && (state_r == IDLE);
  assign cmd_in_range_s = ({1'b0, cmd.cmd_ch} < 5'(NUM_CH));

  // Scan sequencing: IDLE until a frame boundary, then one channel per cycle.
  always_comb begin
    state_nxt_s  = state_r;
    ch_idx_nxt_s = ch_idx_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) begin
          state_nxt_s  = SCAN;
          ch_idx_nxt_s = '0;
        end else begin
          state_nxt_s  = IDLE;
          ch_idx_nxt_s = ch_idx_r;
        end
      end
      SCAN: begin
        if (ch_idx_r == CW'(NUM_CH - 1)) begin
          state_nxt_s  = IDLE;
          ch_idx_nxt_s = '0;
        end else begin
          state_nxt_s  = SCAN;
          ch_idx_nxt_s = ch_idx_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        ch_idx_nxt_s = '0;
      end
    endcase
  end

  // The ramp for a SCAN slot is computed on the edge that enters the slot, so the
  // registered duty and latch both appear during that slot. A command accepted on the
  // frame_start edge is forwarded so it lands in the same frame.
  assign proc_en_s = (state_nxt_s == SCAN);

  // Select the channel being ramped, with command bypass for its target.
  always_comb begin
    proc_cur_s = cur_r[0];
    proc_tgt_s = tgt_r[0];
    for (int k = 0; k < NUM_CH; k++) begin
      proc_cur_s = (ch_idx_nxt_s == CW'(k)) ? cur_r[k] : proc_cur_s;
      proc_tgt_s = (ch_idx_nxt_s == CW'(k)) ? tgt_r[k] : proc_tgt_s;
    end
    proc_tgt_s = (accept_s && cmd_in_range_s && ({1'b0, cmd.cmd_ch} == 5'(ch_idx_nxt_s)))
                 ? cmd.cmd_target : proc_tgt_s;
  end

  assign diff_s = $signed({1'b0, proc_tgt_s}) - $signed({1'b0, proc_cur_s});

  // Rate-limited step; a full step only happens when the gap exceeds STEP, so no overshoot or wrap.
  always_comb begin
    proc_new_s = proc_tgt_s;
    if (diff_s > STEP_S) begin
      proc_new_s = proc_cur_s + DUTY_W'(STEP);
    end else if (diff_s < -STEP_S) begin
      proc_new_s = proc_cur_s - DUTY_W'(STEP);
    end else begin
      proc_new_s = proc_tgt_s;
    end
  end

  // State, targets, duties, latch strobes and error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      ch_idx_r <= '0;
      latch_r  <= '0;
      err_r    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cur_r[k] <= DUTY_W'(INIT_DUTY);
        tgt_r[k] <= DUTY_W'(INIT_DUTY);
      end
    end else begin
      state_r  <= state_nxt_s;
      ch_idx_r <= ch_idx_nxt_s;
      err_r    <= accept_s && !cmd_in_range_s;
      for (int k = 0; k < NUM_CH; k++) begin
        if (accept_s && cmd_in_range_s && (cmd.cmd_ch == 4'(k))) begin
          tgt_r[k] <= cmd.cmd_target;
        end else begin
          tgt_r[k] <= tgt_r[k];
        end
        if (proc_en_s && (ch_idx_nxt_s == CW'(k))) begin
          cur_r[k]   <= proc_new_s;
          latch_r[k] <= 1'b1;
        end else begin
          cur_r[k]   <= cur_r[k];
          latch_r[k] <= 1'b0;
        end
      end
    end
  end

  // Flatten duties and compare against targets.
  always_comb begin
    duty_out  = '0;
    at_target = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      duty_out[k*DUTY_W +: DUTY_W] = cur_r[k];
      at_target[k]                 = (cur_r[k] == tgt_r[k]);
    end
  end

  assign latch = latch_r;

endmodule

// File: tb/tb_servo_sweep_sequencer.sv
// Bench for servo_sweep_sequencer: two instances (STEP 2 and STEP 255) share one command
// stream and are checked every cycle against a frame-level model of targets and duties.
module tb_servo_sweep_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [3:0]  cmd_ch;
  logic [7:0]  cmd_target;
  logic [31:0] duty_a, duty_b;
  logic [3:0]  latch_a, latch_b, at_a, at_b;
  logic        fs_a, fs_b;

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycle n = number of clock edges since reset release
  int n;
  int tgt [4];
  int cur_a [4];
  int cur_b [4];
  int q1[$];
  int q2[$];
  int first_fs;
  int err_seen;

  servo_sweep_sequencer_if if_a ();
  servo_sweep_sequencer_if if_b ();

  assign if_a.cmd_valid  = cmd_valid;
  assign if_a.cmd_ch     = cmd_ch;
  assign if_a.cmd_target = cmd_target;
  assign if_b.cmd_valid  = cmd_valid;
  assign if_b.cmd_ch     = cmd_ch;
  assign if_b.cmd_target = cmd_target;

  servo_sweep_sequencer #(.NUM_CH(4), .CLK_DIV(2), .FRAME_TICKS(8), .STEP(2), .INIT_DUTY(128)) dut_a (
    .clock(clock), .reset(reset), .cmd(if_a), .duty_out(duty_a),
    .latch(latch_a), .at_target(at_a), .frame_start(fs_a)
  );

  servo_sweep_sequencer #(.NUM_CH(4), .CLK_DIV(2), .FRAME_TICKS(8), .STEP(255), .INIT_DUTY(128)) dut_b (
    .clock(clock), .reset(reset), .cmd(if_b), .duty_out(duty_b),
    .latch(latch_b), .at_target(at_b), .frame_start(fs_b)
  );

  always #5 clock = ~clock;

  function automatic bit exp_ready(input int nn);
    return !(nn >= 16 && (nn % 16) < 4);
  endfunction

  function automatic int ramp(input int c, input int t, input int s);
    if (t - c > s) return c + s;
    if (c - t > s) return c - s;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tgt[k] = 128; cur_a[k] = 128; cur_b[k] = 128;
    end
    first_fs = -1;
  endtask

  // Drive one command slot, advance one clock, update the model and compare everything.
  task automatic run_cycle(input bit v, input int ch, input int t);
    logic [31:0] da, db;
    logic [3:0]  la, ata, atb;
    bit          err_exp;
    cmd_valid  = v;
    cmd_ch     = 4'(ch);
    cmd_target = 8'(t);
    @(posedge clock);
    @(negedge clock);
    n++;
    err_exp = 1'b0;
    if (v && exp_ready(n - 1)) begin
      if (ch < 4) tgt[ch] = t;
      else err_exp = 1'b1;
    end
    la = 4'b0;
    if (n >= 16 && (n % 16) < 4) begin
      cur_a[n % 16] = ramp(cur_a[n % 16], tgt[n % 16], 2);
      cur_b[n % 16] = ramp(cur_b[n % 16], tgt[n % 16], 255);
      la[n % 16] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      da[8*k +: 8] = 8'(cur_a[k]);
      db[8*k +: 8] = 8'(cur_b[k]);
      ata[k] = (cur_a[k] == tgt[k]);
      atb[k] = (cur_b[k] == tgt[k]);
    end
    chk("duty_a", duty_a, da);
    chk("duty_b", duty_b, db);
    chk("latch_a", 32'(latch_a), 32'(la));
    chk("latch_b", 32'(latch_b), 32'(la));
    chk("at_target_a", 32'(at_a), 32'(ata));
    chk("at_target_b", 32'(at_b), 32'(atb));
    chk("cmd_ready_a", 32'(if_a.cmd_ready), 32'(exp_ready(n)));
    chk("cmd_ready_b", 32'(if_b.cmd_ready), 32'(exp_ready(n)));
    chk("cmd_err_a", 32'(if_a.cmd_err), 32'(err_exp));
    chk("cmd_err_b", 32'(if_b.cmd_err), 32'(err_exp));
    chk("frame_start_a", 32'(fs_a), 32'((n % 16) == 15));
    chk("frame_start_b", 32'(fs_b), 32'((n % 16) == 15));
    if (latch_a[1]) q1.push_back(int'(duty_a[15:8]));
    if (latch_b[2]) q2.push_back(int'(duty_b[23:16]));
    if (fs_a && first_fs < 0) first_fs = n + 1;
    if (if_a.cmd_err) err_seen++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle(1'b0, 0, 0);
  endtask

  task automatic wait_slot(input int m);
    while (n < 16 || (n % 16) != m) run_cycle(1'b0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_duty_a"}, duty_a, 32'h8080_8080);
    chk({tag, "_duty_b"}, duty_b, 32'h8080_8080);
    chk({tag, "_latch_a"}, 32'(latch_a), 32'h0);
    chk({tag, "_at_target_a"}, 32'(at_a), 32'hf);
    chk({tag, "_ready_a"}, 32'(if_a.cmd_ready), 32'h1);
    chk({tag, "_err_a"}, 32'(if_a.cmd_err), 32'h0);
    chk({tag, "_fs_a"}, 32'(fs_a), 32'h0);
  endtask

  initial begin
    int held;
    bit acc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = 4'd0; cmd_target = 8'd0;
    err_seen = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;
    model_reset();

    // first frame: boundary on cycle 16, all channels latched at centre
    idle(21);
    chk("first_frame_start_cycle", 32'(first_fs), 32'd16);
    chk("centre_duty", duty_a, 32'h8080_8080);

    // ch1 -> 135 ramps 130,132,134,135
    q1.delete();
    run_cycle(1'b1, 1, 135);
    idle(64);
    chk("ramp_len", 32'(q1.size()), 32'd4);
    if (q1.size() == 4) begin
      chk("ramp0", 32'(q1[0]), 32'd130);
      chk("ramp1", 32'(q1[1]), 32'd132);
      chk("ramp2", 32'(q1[2]), 32'd134);
      chk("ramp3", 32'(q1[3]), 32'd135);
    end
    chk("ch1_at_target", 32'(at_a[1]), 32'd1);

    // full-scale jumps with STEP 255: no wrap
    q2.delete();
    wait_slot(6);
    run_cycle(1'b1, 2, 0);
    idle(16);
    run_cycle(1'b1, 2, 255);
    idle(16);
    chk("jump_len", 32'(q2.size()), 32'd2);
    if (q2.size() == 2) begin
      chk("jump_to_0", 32'(q2[0]), 32'd0);
      chk("jump_to_255", 32'(q2[1]), 32'd255);
    end

    // out-of-range channel: single error pulse, nothing moves
    wait_slot(8);
    err_seen = 0;
    run_cycle(1'b1, 7, 99);
    idle(3);
    chk("err_pulses", 32'(err_seen), 32'd1);

    // command on the frame_start cycle lands in that frame's scan
    wait_slot(15);
    run_cycle(1'b1, 0, 140);
    chk("fs_cmd_duty_a", 32'(duty_a[7:0]), 32'd130);
    chk("fs_cmd_duty_b", 32'(duty_b[7:0]), 32'd140);

    // valid held through scan is only taken once idle
    held = 0;
    acc = 1'b0;
    while (!acc && held < 32) begin
      acc = exp_ready(n);
      run_cycle(1'b1, 3, 50);
      held++;
    end
    chk("held_cycles", 32'(held), 32'd5);

    // randomized commands, including bad channels and extremes
    for (int i = 0; i < 800; i++) begin
      int sel;
      int t;
      sel = int'($urandom_range(0, 9));
      t   = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
      run_cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 5)), t);
    end

    // reset in the middle of a scan, right after latch[1]
    wait_slot(1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(21);
    chk("restart_frame_start_cycle", 32'(first_fs), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
